window_sum: RTL

- Streaming window-sum stage that directly feeds the area-based subpixel coefficient stage (the consumer of SM/A/B).
- Accepts one 5-pixel vertical column per valid cycle and keeps a 3-column window (L, M, R).
- For each complete window it produces SM (sum of the middle column), A (left intensity pair) and B (right intensity pair), plus pixel position and a flat-window flag.
- Fully pipelined with no backpressure; the downstream stage accepts every cycle.

---
 rtl/window_sum_pkg.sv | 22 ++
 rtl/win_pos_cnt.sv | 84 ++++++++
 rtl/window_sum.sv | 132 +++++++++++++
 3 files changed

// File: rtl/window_sum_pkg.sv
// Shared widths, pixel-index constants and the pixel-extract helper for window_sum.
package window_sum_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned ROWS  = 5;
  localparam int unsigned COL_W = PIX_W * ROWS;
  localparam int unsigned SM_W  = 11;
  localparam int unsigned AB_W  = 10;

  // Rows feeding the left (A) and right (B) intensity pairs.
  localparam int unsigned IDX_L0 = 0;
  localparam int unsigned IDX_L1 = 1;
  localparam int unsigned IDX_R3 = 3;
  localparam int unsigned IDX_R4 = 4;

  // Row idx of a packed column; row0 sits in the low byte.
  function automatic logic [PIX_W-1:0] pix(input logic [COL_W-1:0] col,
                                           input int unsigned      idx);
    return col[idx*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/win_pos_cnt.sv
// Column/line position tracking for window_sum: column count within the line,
// window-valid strobe, x/y of the middle column and the sticky overflow flag.
module win_pos_cnt #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned X_W   = 10,
  parameter int unsigned Y_W   = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           col_valid_i,
  input  logic           col_sof_i,
  input  logic           col_sol_i,
  output logic           win_vld_o,
  output logic [X_W-1:0] win_x_o,
  output logic [Y_W-1:0] win_y_o,
  output logic           err_ovf_o
);

  localparam int unsigned CNT_W = $clog2(IMG_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IMG_W);
  localparam logic [X_W-1:0]   X_MAX   = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX   = Y_W'(IMG_H - 1);

  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             err_q, err_d;
  logic             vld_q, vld_d;

  // Next-state: sof beats sol; a sol is only a line advance once a line has
  // been seen since reset (col_cnt_q != 0), so the first line of a stream is y=0.
  always_comb begin
    col_cnt_d = col_cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    err_d     = err_q;
    vld_d     = 1'b0;
    if (col_valid_i) begin
      if (col_sof_i) begin
        col_cnt_d = CNT_W'(1);
        y_d       = '0;
        err_d     = 1'b0;
      end else if (col_sol_i) begin
        col_cnt_d = CNT_W'(1);
        if (col_cnt_q != '0) begin
          if (y_q == Y_MAX) err_d = 1'b1;
          else              y_d   = y_q + Y_W'(1);
        end
      end else if (col_cnt_q == CNT_MAX) begin
        err_d = 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + CNT_W'(1);
      end
      vld_d = (col_cnt_d >= CNT_W'(3));
      // Once the line runs past IMG_W the count is pinned, x pins at the last column.
      if (!col_sof_i && !col_sol_i && col_cnt_q == CNT_MAX) x_d = X_MAX;
      else                                                  x_d = X_W'(col_cnt_d) - X_W'(2);
    end
  end

  // Position state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      err_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      col_cnt_q <= col_cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      err_q     <= err_d;
      vld_q     <= vld_d;
    end
  end

  assign win_vld_o = vld_q;
  assign win_x_o   = x_q;
  assign win_y_o   = y_q;
  assign err_ovf_o = err_q;

endmodule

// File: rtl/window_sum.sv
// Streaming 3-column window-sum stage: keeps L/M/R columns and produces
// SM (middle-column sum), A (L0+L1), B (R3+R4) with position and flat flag.
module window_sum
  import window_sum_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned X_W   = 10,
  parameter int unsigned Y_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             col_valid,
  input  logic             col_sof,
  input  logic             col_sol,
  input  logic [COL_W-1:0] col_data,
  output logic [SM_W-1:0]  SM,
  output logic [AB_W-1:0]  A,
  output logic [AB_W-1:0]  B,
  output logic             out_valid,
  output logic             out_flat,
  output logic [X_W-1:0]   out_x,
  output logic [Y_W-1:0]   out_y,
  output logic             err_ovf
);

  logic             win_vld;
  logic [X_W-1:0]   win_x;
  logic [Y_W-1:0]   win_y;

  logic [COL_W-1:0] col_l_q, col_m_q, col_r_q;

  logic [SM_W-1:0]  s1_p_d, s1_p_q;
  logic [SM_W-1:0]  s1_q_d, s1_q_q;
  logic [AB_W-1:0]  s1_a_d, s1_a_q;
  logic [AB_W-1:0]  s1_b_d, s1_b_q;
  logic             s1_vld_q;
  logic [X_W-1:0]   s1_x_q;
  logic [Y_W-1:0]   s1_y_q;

  logic [SM_W-1:0]  sm_q;
  logic [AB_W-1:0]  a_q, b_q;
  logic             vld_q, flat_q;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;

  win_pos_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_pos (
    .clk         (clk),
    .rst         (rst),
    .col_valid_i (col_valid),
    .col_sof_i   (col_sof),
    .col_sol_i   (col_sol),
    .win_vld_o   (win_vld),
    .win_x_o     (win_x),
    .win_y_o     (win_y),
    .err_ovf_o   (err_ovf)
  );

  // Column shift: L <= M <= R <= new column on every valid column.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_l_q <= '0;
      col_m_q <= '0;
      col_r_q <= '0;
    end else if (col_valid) begin
      col_l_q <= col_m_q;
      col_m_q <= col_r_q;
      col_r_q <= col_data;
    end
  end

  // Stage-1 partial sums taken straight from the shift registers.
  always_comb begin
    s1_p_d = SM_W'(pix(col_m_q, 0)) + SM_W'(pix(col_m_q, 1)) + SM_W'(pix(col_m_q, 2));
    s1_q_d = SM_W'(pix(col_m_q, 3)) + SM_W'(pix(col_m_q, 4));
    s1_a_d = AB_W'(pix(col_l_q, IDX_L0)) + AB_W'(pix(col_l_q, IDX_L1));
    s1_b_d = AB_W'(pix(col_r_q, IDX_R3)) + AB_W'(pix(col_r_q, IDX_R4));
  end

  // Two-stage pipeline; data registers only load on valid so outputs hold in bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_p_q   <= '0;
      s1_q_q   <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      vld_q    <= 1'b0;
      sm_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      flat_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      s1_vld_q <= win_vld;
      if (win_vld) begin
        s1_p_q <= s1_p_d;
        s1_q_q <= s1_q_d;
        s1_a_q <= s1_a_d;
        s1_b_q <= s1_b_d;
        s1_x_q <= win_x;
        s1_y_q <= win_y;
      end
      vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        sm_q   <= s1_p_q + s1_q_q;
        a_q    <= s1_a_q;
        b_q    <= s1_b_q;
        flat_q <= (s1_a_q == s1_b_q);
        x_q    <= s1_x_q;
        y_q    <= s1_y_q;
      end
    end
  end

  assign SM        = sm_q;
  assign A         = a_q;
  assign B         = b_q;
  assign out_valid = vld_q;
  assign out_flat  = flat_q;
  assign out_x     = x_q;
  assign out_y     = y_q;

endmodule
